// File: rtl/alu_mux_pipe.sv
// ---------------------------------------------------------------------------
// alu_mux_pipe
//
// Registered N:1 result selector for the ALU datapath. It picks one WIDTH-bit
// lane out of NUM_IN = 2**SEL_BITS candidate results and holds it in a
// single-entry output register. A scan mode steps the select round-robin
// through every lane so a debug path can sweep all results without driving
// sel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers a selection this cycle
//   in_ready   block can accept this cycle (combinational)
//   sel        lane select, used when scan_en = 0
//   scan_en    1 = select with the internal scan_ptr instead of sel
//   inputs     packed lanes, lane i at bits [i*WIDTH +: WIDTH]
//   out_valid  out/out_sel hold an unconsumed word
//   out_ready  downstream accepts the word this cycle
//   out        registered selected lane
//   out_sel    lane index that produced out
//   scan_ptr   current scan pointer
//
// Handshake: a word moves on a rising edge where valid && ready on the same
// side. in_ready = !out_valid || out_ready, so a new word may enter in the
// same edge that the held word drains. out_valid never drops unless the
// downstream side took the word (or reset).
// ---------------------------------------------------------------------------
module alu_mux_pipe #(
    parameter  int WIDTH    = 32,
    parameter  int SEL_BITS = 3,
    localparam int NUM_IN   = 2 ** SEL_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_BITS-1:0]     sel,
    input  logic                    scan_en,
    input  logic [NUM_IN*WIDTH-1:0] inputs,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_BITS-1:0]     out_sel,
    output logic [SEL_BITS-1:0]     scan_ptr
);

    logic [SEL_BITS-1:0] eff_sel;
    logic [WIDTH-1:0]    lane_sel;
    logic                accept;

    assign eff_sel  = scan_en ? scan_ptr : sel;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Every select value maps to a real lane, so the default is never the
    // chosen result; it only keeps the process free of latches.
    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (eff_sel == SEL_BITS'(i)) begin
                lane_sel = inputs[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_sel   <= '0;
            scan_ptr  <= '0;
        end else begin
            if (accept) begin
                // Covers both a plain load and drain-plus-reload in one edge.
                out       <= lane_sel;
                out_sel   <= eff_sel;
                out_valid <= 1'b1;
                if (scan_en) begin
                    // NUM_IN is a power of two, so natural overflow wraps.
                    scan_ptr <= scan_ptr + SEL_BITS'(1);
                end
            end else if (out_ready) begin
                // Drain only; out and out_sel keep their last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_mux_pipe
//
// Bench for alu_mux_pipe with WIDTH=8 / SEL_BITS=3 (main instance) and a
// WIDTH=1 instance for the single-bit mux sweep. A queue-based behavioural
// model tracks the pending word; a per-cycle compare process checks the DUT
// against it, and directed sequences pin literal expected values.
// ---------------------------------------------------------------------------
module tb_alu_mux_pipe;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (WIDTH=8) ----------------
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [2:0]  sel       = '0;
    logic        scan_en   = 1'b0;
    logic [63:0] inputs;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out;
    logic [2:0]  out_sel;
    logic [2:0]  scan_ptr;
    logic [7:0]  lane [8];

    always_comb begin
        inputs = '0;
        for (int i = 0; i < 8; i++) inputs[i*8 +: 8] = lane[i];
    end

    alu_mux_pipe #(.WIDTH(8), .SEL_BITS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .scan_en(scan_en), .inputs(inputs), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_sel(out_sel), .scan_ptr(scan_ptr)
    );

    // ---------------- single-bit DUT (WIDTH=1) ----------------
    logic       w1_in_valid = 1'b0;
    logic       w1_in_ready;
    logic [2:0] w1_sel = '0;
    logic [7:0] w1_inputs = 8'b1010_0110;
    logic       w1_out_valid;
    logic [0:0] w1_out;
    logic [2:0] w1_out_sel;
    logic [2:0] w1_scan_ptr;

    alu_mux_pipe #(.WIDTH(1), .SEL_BITS(3)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .sel(w1_sel), .scan_en(1'b0), .inputs(w1_inputs), .out_valid(w1_out_valid),
        .out_ready(1'b1), .out(w1_out), .out_sel(w1_out_sel), .scan_ptr(w1_scan_ptr)
    );

    // ---------------- counters / check ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // exp_q holds the word the block still owes downstream ({sel, data});
    // m_cur is what out/out_sel must show, pending or already consumed.
    logic [10:0] exp_q [$];
    logic [10:0] m_cur = '0;
    int          m_ptr = 0;
    int          m_eff;
    logic        m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cur = '0;
            m_ptr = 0;
        end else begin
            m_acc = in_valid && ((exp_q.size() == 0) || out_ready);
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (m_acc) begin
                m_eff = scan_en ? m_ptr : int'(sel);
                m_cur = {3'(m_eff), lane[m_eff]};
                exp_q.push_back(m_cur);
                if (scan_en) m_ptr = (m_ptr + 1) % 8;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready",  32'(in_ready),  32'((exp_q.size() == 0) || out_ready));
            check("scan_ptr",  32'(scan_ptr),  32'(m_ptr));
            check("out",       32'(out),       32'(m_cur[7:0]));
            check("out_sel",   32'(out_sel),   32'(m_cur[10:8]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic se, input logic ordy);
        in_valid  = v;
        sel       = s;
        scan_en   = se;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic idle_drain();
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
    endtask

    int w1_tab [8] = '{0, 1, 1, 0, 0, 1, 0, 1};

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 8; i++) lane[i] = 8'h10 + 8'(i);
        #2;
        do_reset();

        // reset state
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out",       32'(out),       32'h00);
        check("rst out_sel",   32'(out_sel),   32'd0);
        check("rst scan_ptr",  32'(scan_ptr),  32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);

        // direct select
        drive(1'b1, 3'd5, 1'b0, 1'b1);
        step();
        check("dir out",       32'(out),       32'h15);
        check("dir out_sel",   32'(out_sel),   32'd5);
        check("dir out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 3'd5, 1'b0, 1'b1);
        step();
        check("dir drain valid", 32'(out_valid), 32'd0);
        check("dir drain out",   32'(out),       32'h15);

        // back-pressure
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        lane[2] = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp out",      32'(out),      32'h12);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        drive(1'b1, 3'd7, 1'b0, 1'b1);
        step();
        check("bp new out",   32'(out),       32'h17);
        check("bp new valid", 32'(out_valid), 32'd1);
        lane[2] = 8'h12;
        idle_drain();

        // scan wrap
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("scan out", 32'(out), 32'(8'h10 + 8'(k % 8)));
        end
        check("scan end ptr", 32'(scan_ptr), 32'd2);
        idle_drain();

        // mixed mode
        do_reset();
        drive(1'b1, 3'd0, 1'b1, 1'b1);
        repeat (3) step();
        check("mix ptr after scan", 32'(scan_ptr), 32'd3);
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            check("mix direct out", 32'(out),      32'h16);
            check("mix direct ptr", 32'(scan_ptr), 32'd3);
        end
        drive(1'b1, 3'd6, 1'b1, 1'b1);
        step();
        check("mix rescan out", 32'(out),      32'h13);
        check("mix rescan ptr", 32'(scan_ptr), 32'd4);
        idle_drain();

        // async reset during a stall
        drive(1'b1, 3'd1, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        step();
        check("stall valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst out",   32'(out),       32'h00);
        check("async rst ptr",   32'(scan_ptr),  32'd0);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        check("no replay valid", 32'(out_valid), 32'd0);

        // single-bit sweep, one cycle delayed
        for (int i = 0; i < 8; i++) begin
            w1_in_valid = 1'b1;
            w1_sel      = 3'(i);
            step();
            check("w1 out",     32'(w1_out),     32'(w1_tab[i]));
            check("w1 out_sel", 32'(w1_out_sel), 32'(i));
        end
        w1_in_valid = 1'b0;

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 8; i++) lane[i] = 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
            step();
        end
        idle_drain();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mux_pipe.md
Name: alu_mux_pipe

Overview:
Parametrised, registered N:1 result selector for the ALU datapath, the successor of the fixed 8:1 single-bit result mux. It selects one WIDTH-bit lane out of 2**SEL_BITS candidate results and captures it in a single-entry output register behind a valid/ready handshake. A scan mode steps the select automatically through all lanes, round-robin, so a bench or a debug path can sweep every operation result without driving sel.

Parameters:
WIDTH, 32, bit width of each input lane and of out.
SEL_BITS, 3, select width; NUM_IN = 2**SEL_BITS input lanes (derived, not overridable).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous assert, active-low; deassertion sampled on clk.
in_valid  input  1  upstream offers a selection this cycle.
in_ready  output  1  block can accept this cycle.
sel  input  SEL_BITS  lane select, used when scan_en=0.
scan_en  input  1  1 = use internal scan_ptr instead of sel.
inputs  input  NUM_IN*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
out_valid  output  1  out/out_sel hold an unconsumed word.
out_ready  input  1  downstream accepts the word this cycle.
out  output  WIDTH  registered selected lane.
out_sel  output  SEL_BITS  lane index that produced out.
scan_ptr  output  SEL_BITS  current scan pointer.

Behaviour:
- Reset (rst_n=0, any time, asynchronous): out_valid=0, out=0, out_sel=0, scan_ptr=0. A pending word is discarded and is not replayed after reset.
- Effective select: eff = scan_en ? scan_ptr : sel. This path is combinational; all outputs are registered except in_ready.
- in_ready = !out_valid || out_ready. This is the only combinational path from out_ready to an output.
- Accept: in_valid && in_ready at a rising edge. On accept: out <= lane[eff], out_sel <= eff, out_valid <= 1.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 word per cycle when out_ready is held at 1.
- Drain only: out_valid && out_ready && !in_valid -> out_valid <= 0. out and out_sel keep their last values.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, and out_valid stays 1.
- Stall: out_valid && !out_ready -> out, out_sel and out_valid are frozen. in_ready=0, so in_valid and inputs are ignored.
- inputs and sel are sampled only at the accept edge. Changes while stalled have no effect.
- scan_ptr:
  - Increments by 1 modulo NUM_IN on each accept with scan_en=1. NUM_IN-1 wraps to 0.
  - Unchanged on accepts with scan_en=0 and on cycles without an accept.
  - Toggling scan_en does not reset scan_ptr.
- Handshake protocol: out_valid never drops without out_ready. in_valid may be asserted and withdrawn freely because no acceptance is implied without in_ready.
- No X propagation: every select value in 0..NUM_IN-1 is legal, so no illegal-select state exists.

Test Plan:
(All tests use WIDTH=8 and SEL_BITS=3, with lane i driven to 0x10+i.)
- Reset: hold rst_n=0, then release -> out_valid=0, out=0x00, out_sel=0, scan_ptr=0, in_ready=1. Assert rst_n=0 mid-stall -> out_valid drops immediately, without waiting for a clk edge.
- Direct select: out_ready=1, in_valid=1, sel=5 for one cycle -> next cycle out=0x15, out_sel=5, out_valid=1. Next cycle with in_valid=0 -> out_valid=0 and out stays 0x15.
- Back-pressure: accept sel=2, hold out_ready=0 for 4 cycles while sel=7 and lane 2 changes to 0xAA -> out stays 0x12 and in_ready=0 throughout. Raise out_ready with in_valid=1, sel=7 -> next out=0x17 in the same edge, with no bubble.
- Scan wrap: scan_en=1, in_valid=1, out_ready=1 for 10 cycles -> out sequence 0x10..0x17, 0x10, 0x11; scan_ptr ends at 2.
- Mixed mode: scan for 3 accepts (scan_ptr=3), switch to scan_en=0 with sel=6 for 2 accepts, then return to scan -> direct outputs are 0x16, 0x16, the next scan output is 0x13, and scan_ptr=3 during the direct phase.
- Width sweep: WIDTH=1, SEL_BITS=3, lane pattern 8'b1010_0110 -> for sel 0..7, out is 0,1,1,0,0,1,0,1, matching the fixed 8:1 mux one cycle delayed.
